// File: rtl/key_pkg.sv
// Shared definitions for the panel-key input stage: channel state encoding and default timing.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_PEND   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_PEND = 2'b11
  } key_state_t;

  // 20 ms debounce and 3 s long-press at a 100 MHz clock
  localparam int unsigned DEBOUNCE_20MS = 32'd2000000;
  localparam int unsigned LONG_PRESS_3S = 32'd300000000;

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce FSM with counter, and long-press hold counter.
// All outputs are registered; the pending states are skipped when DEBOUNCE_CYCLES is 1.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_20MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_3S
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic              SKIP_PEND = (DEBOUNCE_CYCLES == 1);

  logic [1:0]        sync_q;
  logic              s;
  key_state_t        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_d, release_d, long_d, level_d;

  assign s = sync_q[1];

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;

    if (key_level && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    case (state_q)
      RELEASED: begin
        if (s) begin
          if (SKIP_PEND) begin
            state_d    = PRESSED;
            deb_cnt_d  = '0;
            hold_cnt_d = '0;
            press_d    = 1'b1;
          end else begin
            state_d   = PRESS_PEND;
            deb_cnt_d = DEB_ONE;
          end
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (SKIP_PEND) begin
            state_d   = RELEASED;
            deb_cnt_d = '0;
            release_d = 1'b1;
          end else begin
            state_d   = RELEASE_PEND;
            deb_cnt_d = DEB_ONE;
          end
        end
      end
      RELEASE_PEND: begin
        // A bounce back to pressed keeps the hold count, so key_long cannot repeat
        if (s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = RELEASED;
        deb_cnt_d = '0;
      end
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    long_d  = key_level && (hold_cnt_q == HOLD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= RELEASED;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_raw};
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_long    <= long_d;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Panel key front end: one independent key_channel per key bit, wiring only.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS          = 5,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_20MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_3S
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with 2 keys, 4-cycle debounce and 20-cycle long press.
module tb_key_conditioner;

  localparam int unsigned NK = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release, key_long;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  raw;
    int unsigned n;
    logic [1:0]  lvl;
    logic [1:0]  prs;
    logic [1:0]  rel;
    logic [1:0]  lng;
  } vec_t;

  vec_t tbl[$];

  key_conditioner #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [1:0] l, input logic [1:0] p,
                                    input logic [1:0] r, input logic [1:0] g);
    return {l, p, r, g};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {key_level, key_press, key_release, key_long};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
               name, $time, act[7:6], act[5:4], act[3:2], act[1:0],
               exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [7:0] exp, input string name);
    key_raw = r;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  task automatic add(input logic [1:0] r, input int unsigned n, input logic [1:0] l,
                     input logic [1:0] p, input logic [1:0] rl, input logic [1:0] g);
    vec_t v;
    v.raw = r; v.n = n; v.lvl = l; v.prs = p; v.rel = rl; v.lng = g;
    tbl.push_back(v);
  endtask

  initial begin
    // clean press / release
    add(2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(2'b01, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    // short glitch rejected, then a real press
    add(2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add(2'b01, 3, 2'b01, 2'b00, 2'b00, 2'b00);
    // release with bounce 0,1,0
    add(2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 5, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);

    reset   = 1'b1;
    key_raw = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      for (int unsigned j = 0; j < tbl[k].n; j++) begin
        step(tbl[k].raw, pk(tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].lng), $sformatf("tbl%0d", k));
      end
    end

    // long press fires once, re-arms after release
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 46; i++) begin
        step(2'b01, pk((i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00,
                       (i == 26) ? 2'b01 : 2'b00), $sformatf("long_hold%0d", r));
      end
      for (int i = 1; i <= 8; i++) begin
        step(2'b00, pk((i < 6) ? 2'b01 : 2'b00, 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00),
             $sformatf("long_rel%0d", r));
      end
    end

    // two keys together, key 1 released first
    for (int i = 1; i <= 8; i++) begin
      step(2'b11, pk((i >= 6) ? 2'b11 : 2'b00, (i == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00), "dual_press");
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'b01, pk((i >= 6) ? 2'b01 : 2'b11, 2'b00, (i == 6) ? 2'b10 : 2'b00, 2'b00), "dual_rel1");
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'b00, pk((i < 6) ? 2'b01 : 2'b00, 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00), "dual_rel0");
    end

    // asynchronous reset while pressed
    for (int i = 1; i <= 8; i++) begin
      step(2'b01, pk((i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00), "rst_pre");
    end
    #3;
    reset = 1'b1;
    #1;
    check("rst_async", 8'h00);
    @(posedge clk);
    #1;
    check("rst_held", 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(2'b01, pk((i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00), "rst_post");
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'b00, pk((i < 6) ? 2'b01 : 2'b00, 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00), "rst_rel");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Front-end input stage for the panel push-buttons. Synchronises raw asynchronous key inputs, debounces them, and produces clean levels plus single-cycle press, release and long-press pulses. Sits directly upstream of the gesture power control and menu/mode FSMs, which consume key_level and key_press. One instance serves all panel keys.

Parameters:
NUM_KEYS, 5, number of independent key channels (bit i = key i).
DEBOUNCE_CYCLES, 2000000, consecutive stable synchronised samples required to accept a level change (20 ms at 100 MHz); legal range >= 1.
LONG_PRESS_CYCLES, 300000000, cycles key_level must stay high before key_long fires (3 s at 100 MHz); legal range >= 1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
key_raw  input  NUM_KEYS  raw button pins, 1 = pressed, asynchronous to clk.
key_level  output  NUM_KEYS  debounced key state, 1 = pressed.
key_press  output  NUM_KEYS  1-cycle pulse on accepted press.
key_release  output  NUM_KEYS  1-cycle pulse on accepted release.
key_long  output  NUM_KEYS  1-cycle pulse once per hold reaching LONG_PRESS_CYCLES.

Behaviour:
- Reset (async, active-high): all outputs 0, synchroniser flops 0, all counters 0, every channel in RELEASED. Reset asserted mid-operation clears immediately, without waiting for a clock edge.
- Channels are fully independent; simultaneous events on different keys are all reported in the same cycle.
- Sync: two-flop synchroniser per bit; s = second-stage output.
- Per-channel FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  RELEASED: s=1 -> PRESS_PEND, deb_cnt=1.
  PRESS_PEND: s=0 -> RELEASED, deb_cnt=0. s=1 and deb_cnt=DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise deb_cnt+1.
  PRESSED: s=0 -> RELEASE_PEND, deb_cnt=1.
  RELEASE_PEND: s=1 -> PRESSED, deb_cnt=0. s=0 and deb_cnt=DEBOUNCE_CYCLES-1 -> RELEASED. Otherwise deb_cnt+1.
  When DEBOUNCE_CYCLES=1, the pending states are transited in a single cycle.
- key_level = 1 in PRESSED and RELEASE_PEND. All outputs are registered.
- Latency: raw change held stable -> key_level change exactly 2 + DEBOUNCE_CYCLES clock edges later. Any bounce shorter than DEBOUNCE_CYCLES synchronised samples produces no output activity.
- key_press is high for exactly the first cycle key_level=1. key_release is high for exactly the first cycle key_level=0 after a pressed period.
- Hold counter: cleared on entry to PRESSED. It increments every cycle key_level=1 (including RELEASE_PEND) and saturates at LONG_PRESS_CYCLES.
  key_long pulses in the cycle the counter reaches LONG_PRESS_CYCLES (LONG_PRESS_CYCLES cycles after key_press). It does not repeat while held and re-arms only after an accepted release.
  key_press and key_long never coincide.
- Counter widths: $clog2(parameter+1) bits; no wrap-around is possible.

Decomposition:
- Shared package key_pkg: channel state encoding (RELEASED=2'b00, PRESS_PEND=2'b01, PRESSED=2'b10, RELEASE_PEND=2'b11) and default timing constants DEBOUNCE_20MS and LONG_PRESS_3S.
- Sub-module key_channel: one synchroniser, FSM, debounce counter and hold counter. Instantiated NUM_KEYS times via generate in key_conditioner; the top contains only wiring.

Test Plan:
Use NUM_KEYS=2, DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20 in the bench.
1. key_raw[0] 0->1 held -> key_level[0]=1 and key_press[0]=1 (single cycle) 6 edges later; key_release and key_long stay 0.
2. key_raw[0] pulses high for 3 cycles, then low -> no output activity at all; a subsequent stable high behaves as in scenario 1.
3. Pressed key bounces 1,0,1,0 at 1-cycle intervals, then settles at 0 -> key_release[0] pulses once 6 edges after the final 0; key_level[0] falls in the same cycle.
4. key_raw[0] held for 40 cycles after key_press -> key_long[0] pulses exactly once, 20 cycles after key_press; no repeat; after release and a new press, it fires again.
5. Both keys pressed in the same cycle -> key_press=2'b11 in one cycle; key_raw[1] released early -> key_release[1] only, while key 0 remains unaffected.
6. reset asserted while key_level[0]=1, with key_raw held -> outputs 0 immediately; after reset deasserts -> key_press[0] 6 edges later.
